// File: rtl/ariane_axi_pkg.sv
// Minimal Ariane AXI request/response struct pair as seen at the core master port.
// Only the channel fields the rest of the codebase references are modelled.
package ariane_axi;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;

  typedef logic [IdWidth-1:0] id_t;

  typedef struct packed {
    id_t                  id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
  } ax_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_t                  id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_perf_pkg.sv
// Shared types and helpers for the AXI performance counters.
// All widths handled by sat_add must be 64 bits or less.
package axi_perf_pkg;

  localparam int unsigned TsWidthDef  = 16;
  localparam int unsigned CntWidthDef = 32;
  localparam int unsigned SumWidthDef = 48;

  typedef logic [TsWidthDef-1:0]  ts_t;
  typedef logic [CntWidthDef-1:0] cnt_t;
  typedef logic [SumWidthDef-1:0] lat_sum_t;

  typedef enum logic {
    DirRd = 1'b0,
    DirWr = 1'b1
  } dir_e;

  // Adds a and b, clamping to the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    if (sum > lim) begin
      return lim[63:0];
    end else begin
      return sum[63:0];
    end
  endfunction

endpackage

// File: rtl/lat_ts_fifo.sv
// Small timestamp FIFO tracking outstanding requests of one AXI ID in one direction.
// Depth must be a power of two so the pointers wrap naturally.
module lat_ts_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned    PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0]  FullCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_r [Depth];
  logic [PtrW-1:0]  wr_ptr_r;
  logic [PtrW-1:0]  rd_ptr_r;
  logic [PtrW:0]    cnt_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (cnt_r == FullCnt);
  assign empty_o   = (cnt_r == '0);
  assign data_o    = mem_r[rd_ptr_r];
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Storage, pointers and occupancy; push and pop may land in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      for (int unsigned k = 0; k < Depth; k++) begin
        mem_r[k] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= wr_ptr_r + PtrW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PtrW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + (PtrW + 1)'(1'b1);
        2'b01:   cnt_r <= cnt_r - (PtrW + 1)'(1'b1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/axi_lat_monitor.sv
// Passive AXI latency monitor: timestamps requests per ID and direction and
// accumulates count / sum / max of completion latency for reads and writes.
module axi_lat_monitor
  import axi_perf_pkg::*;
#(
  parameter int unsigned TsWidth        = TsWidthDef,
  parameter int unsigned CntWidth       = CntWidthDef,
  parameter int unsigned SumWidth       = SumWidthDef,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                clear_i,
  input  ariane_axi::req_t    axi_req_i,
  input  ariane_axi::resp_t   axi_resp_i,
  output logic [CntWidth-1:0] rd_cnt_o,
  output logic [SumWidth-1:0] rd_lat_sum_o,
  output logic [TsWidth-1:0]  rd_lat_max_o,
  output logic [CntWidth-1:0] wr_cnt_o,
  output logic [SumWidth-1:0] wr_lat_sum_o,
  output logic [TsWidth-1:0]  wr_lat_max_o,
  output logic                ovf_o,
  output logic                orphan_o
);

  localparam int unsigned IdWidth = ariane_axi::IdWidth;
  localparam int unsigned NumIds  = 1 << IdWidth;

  logic [TsWidth-1:0]  ts_r;
  logic [1:0]          req_hs_s;
  logic [1:0]          rsp_hs_s;
  logic [IdWidth-1:0]  req_id_s   [2];
  logic [IdWidth-1:0]  rsp_id_s   [2];
  logic [NumIds-1:0]   push_s     [2];
  logic [NumIds-1:0]   pop_s      [2];
  logic [NumIds-1:0]   full_s     [2];
  logic [NumIds-1:0]   empty_s    [2];
  logic [TsWidth-1:0]  head_s     [2][NumIds];
  logic [TsWidth-1:0]  lat_s      [2];
  logic [1:0]          req_full_s;
  logic [1:0]          rsp_empty_s;
  logic [1:0]          pop_hit_s;
  logic [CntWidth-1:0] cnt_r      [2];
  logic [SumWidth-1:0] sum_r      [2];
  logic [TsWidth-1:0]  max_r      [2];
  logic                ovf_r;
  logic                orphan_r;
  logic                unused_bus_s;

  // Only handshake, ID and last fields matter; the rest of the bus is ignored.
  assign unused_bus_s = ^{axi_req_i, axi_resp_i};

  // Channel handshakes mapped onto the direction index (DirRd / DirWr).
  always_comb begin
    req_hs_s[DirRd] = axi_req_i.ar_valid & axi_resp_i.ar_ready;
    req_id_s[DirRd] = axi_req_i.ar.id;
    rsp_hs_s[DirRd] = axi_resp_i.r_valid & axi_req_i.r_ready & axi_resp_i.r.last;
    rsp_id_s[DirRd] = axi_resp_i.r.id;
    req_hs_s[DirWr] = axi_req_i.aw_valid & axi_resp_i.aw_ready;
    req_id_s[DirWr] = axi_req_i.aw.id;
    rsp_hs_s[DirWr] = axi_resp_i.b_valid & axi_req_i.b_ready;
    rsp_id_s[DirWr] = axi_resp_i.b.id;
  end

  // Per-FIFO push/pop strobes and latency of the head entry being retired.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      push_s[d]      = '0;
      pop_s[d]       = '0;
      req_full_s[d]  = full_s[d][req_id_s[d]];
      rsp_empty_s[d] = empty_s[d][rsp_id_s[d]];
      pop_hit_s[d]   = en_i & rsp_hs_s[d] & ~rsp_empty_s[d];
      lat_s[d]       = ts_r - head_s[d][rsp_id_s[d]];
      if (en_i && req_hs_s[d] && !req_full_s[d]) begin
        push_s[d][req_id_s[d]] = 1'b1;
      end else begin
        push_s[d] = '0;
      end
      if (pop_hit_s[d]) begin
        pop_s[d][rsp_id_s[d]] = 1'b1;
      end else begin
        pop_s[d] = '0;
      end
    end
  end

  for (genvar d = 0; d < 2; d++) begin : g_dir
    for (genvar i = 0; i < NumIds; i++) begin : g_id
      lat_ts_fifo #(
        .Depth (MaxOutstanding),
        .Width (TsWidth)
      ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push_s[d][i]),
        .pop_i   (pop_s[d][i]),
        .data_i  (ts_r),
        .data_o  (head_s[d][i]),
        .full_o  (full_s[d][i]),
        .empty_o (empty_s[d][i])
      );
    end
  end

  // Timestamp, saturating statistics and sticky error flags; clear beats any event.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      ts_r     <= '0;
      ovf_r    <= 1'b0;
      orphan_r <= 1'b0;
      for (int d = 0; d < 2; d++) begin
        cnt_r[d] <= '0;
        sum_r[d] <= '0;
        max_r[d] <= '0;
      end
    end else begin
      if (en_i) begin
        ts_r <= ts_r + TsWidth'(1'b1);
      end
      ovf_r    <= ovf_r | (en_i & |(req_hs_s & req_full_s));
      orphan_r <= orphan_r | (en_i & |(rsp_hs_s & rsp_empty_s));
      for (int d = 0; d < 2; d++) begin
        if (pop_hit_s[d]) begin
          cnt_r[d] <= CntWidth'(sat_add(64'(cnt_r[d]), 64'd1, CntWidth));
          sum_r[d] <= SumWidth'(sat_add(64'(sum_r[d]), 64'(lat_s[d]), SumWidth));
          if (lat_s[d] > max_r[d]) begin
            max_r[d] <= lat_s[d];
          end
        end
      end
    end
  end

  assign rd_cnt_o     = cnt_r[DirRd];
  assign rd_lat_sum_o = sum_r[DirRd];
  assign rd_lat_max_o = max_r[DirRd];
  assign wr_cnt_o     = cnt_r[DirWr];
  assign wr_lat_sum_o = sum_r[DirWr];
  assign wr_lat_max_o = max_r[DirWr];
  assign ovf_o        = ovf_r;
  assign orphan_o     = orphan_r;

endmodule
